// File: rtl/uart_rx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_parity
// Brief    : Oversampled UART receiver, 8 data bits LSB first, one stop bit.
//            Define UART_RX_PARITY_EN to add an even-parity bit (11-bit frame).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_parity #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       rx,
    input  logic       ready_clr,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OS_W  = $clog2(OVERSAMPLE);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_OS_W-1:0]  c_OS_MID   = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_meta;
    logic                r_rxs;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_OS_W-1:0]   r_os;
    logic [2:0]          r_idx;
    logic [7:0]          r_shift;
    logic [7:0]          r_data;
    logic                r_ready;
    logic                r_ferr;
    logic                r_ovr;
    logic                w_tick;
    logic                w_mid;
    logic                w_full;
    logic                w_start_det;
    logic                w_done;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_meta <= 1'b1;
            r_rxs  <= 1'b1;
        end else begin
            r_meta <= rx;
            r_rxs  <= r_meta;
        end
    end

    assign w_tick = (r_div == c_DIV_LAST);
    assign w_mid  = w_tick && (r_os == c_OS_MID);
    assign w_full = w_tick && (r_os == c_OS_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start_det = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) begin
                    w_next      = S_START;
                    w_start_det = 1'b1;
                end
            end
            S_START: begin
                if (w_mid) begin
                    w_next = r_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_full) begin
                    w_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_full) begin
                    w_done = 1'b1;
                    w_next = r_rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (r_rxs) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Both counters realign to the start-bit edge so the mid-bit sample point
    // is measured from the falling edge, not from the free-running phase.
    always_ff @(posedge clk) begin
        if (clear || w_start_det) begin
            r_div <= '0;
            r_os  <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (w_full || ((r_state == S_START) && w_mid)) begin
                r_os <= '0;
            end else begin
                r_os <= r_os + 1'b1;
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (r_state == S_START) begin
            r_idx <= '0;
        end else if ((r_state == S_DATA) && w_full) begin
            r_shift[r_idx] <= r_rxs;
            r_idx          <= r_idx + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_perr <= 1'b0;
        end else if ((r_state == S_PARITY) && w_full) begin
            r_perr <= r_rxs ^ (^r_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_parity_err <= 1'b0;
        end else if (w_done) begin
            r_parity_err <= r_perr;
        end else if (ready_clr) begin
            r_parity_err <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // Frame completion takes priority over a coincident ready_clr.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            r_data  <= r_shift;
            r_ready <= 1'b1;
            r_ferr  <= ~r_rxs;
            r_ovr   <= ready_clr ? 1'b0 : (r_ovr | r_ready);
        end else if (ready_clr) begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign ready     = r_ready;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule
`default_nettype wire
